// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode presets and the field-sum helper
// used to size the raster counters.
package vga_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FRONT  = 16;
  localparam int M640_H_SYNC   = 96;
  localparam int M640_H_BACK   = 48;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FRONT  = 10;
  localparam int M640_V_SYNC   = 2;
  localparam int M640_V_BACK   = 33;
  localparam bit M640_H_POL    = 1'b0;
  localparam bit M640_V_POL    = 1'b0;
  localparam int M640_PIX_KHZ  = 25175;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
  localparam int M800_H_ACTIVE = 800;
  localparam int M800_H_FRONT  = 40;
  localparam int M800_H_SYNC   = 128;
  localparam int M800_H_BACK   = 88;
  localparam int M800_V_ACTIVE = 600;
  localparam int M800_V_FRONT  = 1;
  localparam int M800_V_SYNC   = 4;
  localparam int M800_V_BACK   = 23;
  localparam bit M800_H_POL    = 1'b1;
  localparam bit M800_V_POL    = 1'b1;
  localparam int M800_PIX_KHZ  = 40000;

  function automatic int field_total(input int active, input int front,
                                     input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping next-position counter with combinational decode of
// sync (at the configured polarity), active region and wrap for that position.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  parameter bit POL    = 1'b0,
  localparam int TOTAL = field_total(ACTIVE, FRONT, SYNC, BACK),
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         active,
  output logic         wrap
);

  if ((ACTIVE < 1) || (FRONT < 1) || (SYNC < 1) || (BACK < 1)) begin : g_bad_fields
    $error("vga_axis_counter: every timing field must be at least 1");
  end

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FRONT);
  localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FRONT + SYNC - 1);

  logic in_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

  assign wrap    = (count == LAST);
  assign active  = (count < ACTIVE_END);
  assign in_sync = (count >= SYNC_FIRST) && (count <= SYNC_LAST);
  assign sync    = in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two axis counters hold the next position; every
// enabled clock registers that position together with its sync/active/strobe flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = M640_H_ACTIVE,
  parameter int H_FRONT    = M640_H_FRONT,
  parameter int H_SYNC     = M640_H_SYNC,
  parameter int H_BACK     = M640_H_BACK,
  parameter int V_ACTIVE   = M640_V_ACTIVE,
  parameter int V_FRONT    = M640_V_FRONT,
  parameter int V_SYNC     = M640_V_SYNC,
  parameter int V_BACK     = M640_V_BACK,
  parameter bit H_SYNC_POL = M640_H_POL,
  parameter bit V_SYNC_POL = M640_V_POL,
  localparam int H_TOTAL   = field_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL   = field_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
  localparam int COL_W     = $clog2(H_TOTAL),
  localparam int ROW_W     = $clog2(V_TOTAL)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Pix_En,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic [COL_W-1:0] o_Col,
  output logic [ROW_W-1:0] o_Row,
  output logic             o_Line_Start,
  output logic             o_Frame_Start
);

  logic [COL_W-1:0] h_next;
  logic [ROW_W-1:0] v_next;
  logic             h_sync;
  logic             v_sync;
  logic             h_active;
  logic             v_active;
  logic             h_wrap;
  // The frame boundary is decoded from the counts directly, so vertical wrap has no consumer.
  logic             v_wrap_unused;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (H_SYNC_POL)
  ) u_h_axis (
    .clk     (i_Clk),
    .reset   (i_Reset),
    .advance (i_Pix_En),
    .count   (h_next),
    .sync    (h_sync),
    .active  (h_active),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (V_SYNC_POL)
  ) u_v_axis (
    .clk     (i_Clk),
    .reset   (i_Reset),
    .advance (h_wrap & i_Pix_En),
    .count   (v_next),
    .sync    (v_sync),
    .active  (v_active),
    .wrap    (v_wrap_unused)
  );

  // Strobes drop on disabled clocks so they stay one clock wide at any pixel rate.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Col         <= '0;
      o_Row         <= '0;
      o_HSync       <= ~H_SYNC_POL;
      o_VSync       <= ~V_SYNC_POL;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else if (i_Pix_En) begin
      o_Col         <= h_next;
      o_Row         <= v_next;
      o_HSync       <= h_sync;
      o_VSync       <= v_sync;
      o_Active      <= h_active & v_active;
      o_Line_Start  <= (h_next == '0);
      o_Frame_Start <= (h_next == '0) && (v_next == '0);
    end else begin
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: 640x480, 800x600 and a tiny raster run
// side by side against a position model, plus directed tables and corner sequences.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp;
  } mode_t;

  typedef struct {
    logic rst, en;
    int   col, row;
    logic hs, vs, act, ls, fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state shared by all three rasters (they see the same reset/enable)
  bit valid  = 1'b0;
  int p      = -1;
  bit en_now = 1'b0;

  mode_t MA, MB, MC;

  logic       a_hs, a_vs, a_act, a_ls, a_fs;
  logic [9:0] a_col, a_row;
  logic       b_hs, b_vs, b_act, b_ls, b_fs;
  logic [10:0] b_col;
  logic [9:0]  b_row;
  logic       c_hs, c_vs, c_act, c_ls, c_fs;
  logic [3:0] c_col;
  logic [2:0] c_row;

  vga_timing_gen dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Pix_En(en),
    .o_HSync(a_hs), .o_VSync(a_vs), .o_Active(a_act),
    .o_Col(a_col), .o_Row(a_row), .o_Line_Start(a_ls), .o_Frame_Start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(M800_H_ACTIVE), .H_FRONT(M800_H_FRONT), .H_SYNC(M800_H_SYNC), .H_BACK(M800_H_BACK),
    .V_ACTIVE(M800_V_ACTIVE), .V_FRONT(M800_V_FRONT), .V_SYNC(M800_V_SYNC), .V_BACK(M800_V_BACK),
    .H_SYNC_POL(M800_H_POL), .V_SYNC_POL(M800_V_POL)
  ) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Pix_En(en),
    .o_HSync(b_hs), .o_VSync(b_vs), .o_Active(b_act),
    .o_Col(b_col), .o_Row(b_row), .o_Line_Start(b_ls), .o_Frame_Start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) dut_c (
    .i_Clk(clk), .i_Reset(rst), .i_Pix_En(en),
    .o_HSync(c_hs), .o_VSync(c_vs), .o_Active(c_act),
    .o_Col(c_col), .o_Row(c_row), .o_Line_Start(c_ls), .o_Frame_Start(c_fs)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [28:0] model(input mode_t m);
    int ht, vt, col, row;
    logic hs, vs, act, ls, fs;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    if (!valid) return {12'd0, 12'd0, ~m.hp[0], ~m.vp[0], 3'b000};
    col = p % ht;
    row = (p / ht) % vt;
    hs  = (col >= m.ha + m.hf && col < m.ha + m.hf + m.hs) ? m.hp[0] : ~m.hp[0];
    vs  = (row >= m.va + m.vf && row < m.va + m.vf + m.vs) ? m.vp[0] : ~m.vp[0];
    act = (col < m.ha) && (row < m.va);
    ls  = en_now && (col == 0);
    fs  = ls && (row == 0);
    return {12'(col), 12'(row), hs, vs, act, ls, fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      valid = 1'b0; p = -1; en_now = 1'b0;
    end else if (en) begin
      valid = 1'b1; p++; en_now = 1'b1;
    end else begin
      en_now = 1'b0;
    end
    #1;
    check("model_640", {12'(a_col), 12'(a_row), a_hs, a_vs, a_act, a_ls, a_fs}, model(MA));
    check("model_800", {12'(b_col), 12'(b_row), b_hs, b_vs, b_act, b_ls, b_fs}, model(MB));
    check("model_tiny", {12'(c_col), 12'(c_row), c_hs, c_vs, c_act, c_ls, c_fs}, model(MC));
  endtask

  task automatic pulse_reset();
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    int a_hs_low, a_act_n, a_ls_n, b_hs_hi, b_ls_first, b_ls_second;
    int c_ls80, c_vs_low80, c_fs_n;
    int ls_first, ls_second, ls_n, wide, hold_err;
    logic prev_ls;
    logic [9:0] prev_col;

    MA = '{M640_H_ACTIVE, M640_H_FRONT, M640_H_SYNC, M640_H_BACK,
           M640_V_ACTIVE, M640_V_FRONT, M640_V_SYNC, M640_V_BACK, 0, 0};
    MB = '{M800_H_ACTIVE, M800_H_FRONT, M800_H_SYNC, M800_H_BACK,
           M800_V_ACTIVE, M800_V_FRONT, M800_V_SYNC, M800_V_BACK, 1, 1};
    MC = '{4, 2, 3, 1, 3, 1, 2, 2, 1, 0};
    $display("presets: 640x480 at %0d kHz, 800x600 at %0d kHz", M640_PIX_KHZ, M800_PIX_KHZ);

    // tiny raster: H 4/2/3/1 (total 10, hsync cols 6..8 high), V 3/1/2/2 (total 8, vsync rows 4..5 low)
    //            rst en col row hs vs act ls fs
    tbl[0]  = '{0, 1, 0, 0, 0, 1, 1, 1, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 2, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 3, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 4, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 5, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 6, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 6, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 7, 0, 1, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 8, 0, 1, 1, 0, 0, 0};
    tbl[11] = '{0, 1, 9, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 0, 1, 1, 1, 0};
    tbl[13] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 1, 1, 1, 1};

    // reset state
    rst = 1'b1; en = 1'b0;
    repeat (3) tick();
    check("reset_640", {12'(a_col), 12'(a_row), a_hs, a_vs, a_act, a_ls, a_fs}, {24'd0, 5'b11000});
    check("reset_800", {12'(b_col), 12'(b_row), b_hs, b_vs, b_act, b_ls, b_fs}, {24'd0, 5'b00000});

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; en = tbl[i].en;
      tick();
      check($sformatf("table_tiny[%0d]", i),
            {12'(c_col), 12'(c_row), c_hs, c_vs, c_act, c_ls, c_fs},
            {12'(tbl[i].col), 12'(tbl[i].row), tbl[i].hs, tbl[i].vs, tbl[i].act, tbl[i].ls, tbl[i].fs});
    end

    // full-rate run from reset
    pulse_reset();
    en = 1'b1;
    a_hs_low = 0; a_act_n = 0; a_ls_n = 0; b_hs_hi = 0; b_ls_first = -1; b_ls_second = -1;
    c_ls80 = 0; c_vs_low80 = 0; c_fs_n = 0;
    for (int k = 0; k < 2112; k++) begin
      tick();
      if (k < 1600) begin
        if (!a_hs) a_hs_low++;
        if (a_act) a_act_n++;
        if (a_ls) a_ls_n++;
      end
      if (b_hs) b_hs_hi++;
      if (b_ls) begin
        if (b_ls_first < 0) b_ls_first = k;
        else if (b_ls_second < 0) b_ls_second = k;
      end
      if (k < 80) begin
        if (c_ls) c_ls80++;
        if (!c_vs) c_vs_low80++;
      end
      if (c_fs) c_fs_n++;
    end
    check("hsync_low_640_2lines", a_hs_low, 192);
    check("active_640_2lines", a_act_n, 1280);
    check("line_starts_640", a_ls_n, 2);
    check("hsync_high_800_2lines", b_hs_hi, 256);
    check("line_period_800", b_ls_second - b_ls_first, 1056);
    check("line_starts_tiny_frame", c_ls80, 8);
    check("vsync_low_tiny_frame", c_vs_low80, 20);
    check("frame_starts_tiny", c_fs_n, 27);

    // end-of-frame wrap on the tiny raster
    pulse_reset();
    en = 1'b1;
    repeat (80) tick();
    check("eof_last_pixel", {12'(c_col), 12'(c_row), c_act, c_ls, c_fs}, {12'd9, 12'd7, 3'b000});
    tick();
    check("eof_wrap_to_origin", {12'(c_col), 12'(c_row), c_act, c_ls, c_fs}, {12'd0, 12'd0, 3'b111});

    // half-rate enable
    pulse_reset();
    ls_first = -1; ls_second = -1; ls_n = 0; wide = 0; hold_err = 0;
    prev_ls = 1'b0; prev_col = '0;
    for (int k = 0; k < 3200; k++) begin
      en = (k % 2 == 0);
      tick();
      if (a_ls) begin
        ls_n++;
        if (ls_first < 0) ls_first = k;
        else if (ls_second < 0) ls_second = k;
      end
      if (a_ls && prev_ls) wide++;
      if (!en && (a_col != prev_col)) hold_err++;
      prev_ls = a_ls; prev_col = a_col;
    end
    check("half_rate_line_period", ls_second - ls_first, 1600);
    check("half_rate_line_starts", ls_n, 2);
    check("half_rate_strobe_width", wide, 0);
    check("half_rate_col_hold", hold_err, 0);

    // mid-frame reset on the tiny raster at (row 5, col 4)
    pulse_reset();
    en = 1'b1;
    repeat (55) tick();
    check("midframe_position", {12'(c_col), 12'(c_row)}, {12'd4, 12'd5});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midframe_reset[%0d]", i),
            {12'(c_col), 12'(c_row), c_hs, c_vs, c_act, c_ls, c_fs}, {24'd0, 5'b01000});
    end
    rst = 1'b0;
    tick();
    check("after_reset_origin", {12'(c_col), 12'(c_row), c_act, c_ls, c_fs}, {12'd0, 12'd0, 3'b111});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It produces horizontal and vertical sync, an active-video flag, pixel column and row coordinates, and line-start and frame-start strobes. Every timing field, sync polarity and the pixel rate (through a clock-enable) is configurable. It sits between the board clock and the pixel/colour pipeline, which consumes its coordinates and flags to drive the VGA DAC pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of o_HSync (0 = active-low)
- V_SYNC_POL, 0, asserted level of o_VSync
- Derived: H_TOTAL = sum of H fields; V_TOTAL = sum of V fields; COL_W = $clog2(H_TOTAL); ROW_W = $clog2(V_TOTAL)

Ports:
- i_Clk  in  1  system clock; the only clock
- i_Reset  in  1  reset; synchronous, active-high
- i_Pix_En  in  1  pixel-rate enable; raster advances one pixel per clock with i_Pix_En=1
- o_HSync  out  1  horizontal sync at configured polarity
- o_VSync  out  1  vertical sync at configured polarity
- o_Active  out  1  current pixel is visible (col < H_ACTIVE and row < V_ACTIVE)
- o_Col  out  COL_W  current column, 0..H_TOTAL-1
- o_Row  out  ROW_W  current row, 0..V_TOTAL-1
- o_Line_Start  out  1  one-clock strobe, current pixel has col = 0
- o_Frame_Start  out  1  one-clock strobe, current pixel is (0,0)

## Operation
- Internal next-position counters h_next and v_next. On each i_Pix_En=1 clock, the outputs take the position (h_next, v_next), and the counters advance.
- Horizontal: h_next wraps from H_TOTAL-1 to 0. Vertical advances only on horizontal wrap, and wraps from V_TOTAL-1 to 0.
- HSync is asserted when col is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]. VSync is asserted when row is in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]. VSync is a function of row only, so it changes at col 0.
- Deasserted sync level = ~POL.
- With i_Pix_En=0: o_Col, o_Row, o_HSync, o_VSync and o_Active hold their values. o_Line_Start and o_Frame_Start go to 0, so strobes are exactly one clock wide at any pixel rate.
- o_Col and o_Row keep counting through blanking. The pixel pipeline gates on o_Active.
- Counter compare and add widths are COL_W and ROW_W. A count never exceeds TOTAL-1; there is no overflow state.
- Every field parameter must be at least 1. An elaboration-time check fails otherwise.

## Timing
- Reset, while i_Reset=1 at a clock edge:
  - h_next = 0, v_next = 0
  - o_Col = 0, o_Row = 0
  - o_HSync = ~H_SYNC_POL, o_VSync = ~V_SYNC_POL
  - o_Active = 0, o_Line_Start = 0, o_Frame_Start = 0
- Reset has priority over i_Pix_En. Reset mid-frame restarts the raster.
- The first i_Pix_En=1 clock after reset deasserts presents pixel (0,0), with o_Active=1, o_Line_Start=1 and o_Frame_Start=1.
- All outputs are registered and mutually aligned: within a clock, the flags and strobes describe exactly (o_Col, o_Row). There is no combinational path from input to output.
- Period with i_Pix_En tied high: line = H_TOTAL clocks; frame = H_TOTAL*V_TOTAL clocks.
- Simultaneous horizontal and vertical wrap at (H_TOTAL-1, V_TOTAL-1) produces (0,0) with both strobes set on the next enabled clock.

## Structure
- Shared package vga_pkg holds mode presets as localparams:
  - 640x480@60: defaults above, 25.175 MHz, both polarities 0
  - 800x600@60: 800/40/128/88, 600/1/4/23, 40 MHz, both polarities 1
- The package also holds a helper function returning field-sum totals.
- Sub-module vga_axis_counter is instantiated twice (horizontal, vertical). Its parameters are ACTIVE/FRONT/SYNC/BACK/POL. Its inputs are advance and reset; its outputs are count, sync, active and wrap. The vertical instance's advance = horizontal wrap AND i_Pix_En.

## Test plan
- Defaults, i_Pix_En=1 -> o_HSync=0 for exactly cols 656..751 (96 clocks) of each 800-clock line; o_Active high for 640 clocks per visible line.
- Defaults, full frame -> o_VSync=0 for rows 490..491 only; o_Frame_Start pulses once every 420000 clocks; o_Line_Start pulses 525 times per frame.
- i_Pix_En high every 2nd clock -> line = 1600 clocks; o_Col holds on disabled clocks; every strobe is 1 clock wide.
- Assert i_Reset at (row 300, col 400) for 3 clocks -> outputs show reset values during reset; the first enabled clock after reset gives (0,0) with o_Frame_Start=1.
- 800x600 preset -> H_TOTAL=1056, V_TOTAL=628, o_HSync=1 for cols 840..967, o_VSync=1 for rows 601..604.
- End-of-frame wrap -> (1055,627) is followed by (0,0) on the next enabled clock, with o_Line_Start=1 and o_Frame_Start=1 in the same clock.
